// File: rtl/stream_demux_router_pkg.sv
// Shared types for the 1-to-N stream demux router.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: demux_state_t (skid occupancy), STATS_W (stats counter width), sat_inc (saturating +1).
package stream_demux_router_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } demux_state_t;

  localparam int STATS_W = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stream_demux_skid.sv
// 2-entry skid buffer (main + skid registers) carrying one opaque payload word per beat.
// Latency: 1 cycle, in -> out_valid after the accepting edge.
// Backpressure: in_ready comes only from the state register (deasserted when FULL).
// Ports: clk/rst (async active-high), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module stream_demux_skid
  import stream_demux_router_pkg::*;
#(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  demux_state_t  state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          push;
  logic          pop;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_d = in_data;
        end else if (push) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/stream_demux_router.sv
// Registered 1-to-N stream demux: each input beat goes to the lane named by I_sel, in strict order.
// Latency: 1 cycle, accept at edge t -> O_valid visible after edge t.
// Backpressure: I_ready is registered (low only when 2 beats held); a stalled head lane blocks all lanes.
// Ports: CLK, ASYNCRESET (async active-high; release must already be synchronous to CLK),
//   I_data/I_sel/I_valid/I_ready input stream, O_data (head data broadcast to all lanes),
//   O_valid (one-hot or zero), O_ready per lane, err (1-cycle pulse when an I_sel >= N beat is dropped).
// Optional STREAM_DEMUX_ROUTER_STATS_EN: adds stats (N x 16-bit saturating per-lane pop counts)
//   and drops (16-bit saturating dropped-beat count).
module stream_demux_router
  import stream_demux_router_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int WIDTH = 1,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               CLK,
  input  logic               ASYNCRESET,
  input  logic [WIDTH-1:0]   I_data,
  input  logic [SEL_W-1:0]   I_sel,
  input  logic               I_valid,
  output logic               I_ready,
  output logic [N*WIDTH-1:0] O_data,
  output logic [N-1:0]       O_valid,
  input  logic [N-1:0]       O_ready,
  output logic               err
`ifdef STREAM_DEMUX_ROUTER_STATS_EN
  ,
  output logic [N*STATS_W-1:0] stats,
  output logic [STATS_W-1:0]   drops
`endif
);

  // One extra bit so the range check also compiles cleanly when N is a power of two.
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N);

  logic                   bad;
  logic                   accept;
  logic                   head_valid;
  logic                   head_ready;
  logic [SEL_W+WIDTH-1:0] head;
  logic [SEL_W-1:0]       head_sel;
  logic [WIDTH-1:0]       head_data;
  logic                   err_q;

  assign bad    = ({1'b0, I_sel} >= N_LIM);
  assign accept = I_valid & I_ready;

  // Out-of-range beats are accepted (I_ready is unaffected) but never enter the buffer.
  stream_demux_skid #(
    .PW(SEL_W + WIDTH)
  ) u_skid (
    .clk      (CLK),
    .rst      (ASYNCRESET),
    .in_valid (I_valid & ~bad),
    .in_ready (I_ready),
    .in_data  ({I_sel, I_data}),
    .out_valid(head_valid),
    .out_ready(head_ready),
    .out_data (head)
  );

  assign {head_sel, head_data} = head;

  always_comb begin
    O_valid = '0;
    for (int k = 0; k < N; k++) begin
      O_valid[k] = head_valid && (head_sel == SEL_W'(k));
    end
  end

  // Only the head's lane can pop; other lanes' O_ready is ignored.
  assign head_ready = |(O_valid & O_ready);
  assign O_data     = {N{head_data}};

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) err_q <= 1'b0;
    else            err_q <= accept & bad;
  end

  assign err = err_q;

`ifdef STREAM_DEMUX_ROUTER_STATS_EN
  logic [N*STATS_W-1:0] stats_q;
  logic [STATS_W-1:0]   drops_q;

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      stats_q <= '0;
      drops_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (O_valid[k] && O_ready[k]) begin
          stats_q[k*STATS_W +: STATS_W] <= sat_inc(stats_q[k*STATS_W +: STATS_W]);
        end
      end
      if (accept && bad) drops_q <= sat_inc(drops_q);
    end
  end

  assign stats = stats_q;
  assign drops = drops_q;
`endif

endmodule

// File: tb/tb_stream_demux_router.sv
// Self-checking bench for stream_demux_router (N=3, WIDTH=8): cycle scoreboard plus vector table.
// Latency: n/a (testbench).
// Backpressure: driven by the stimulus (O_ready patterns).
module tb_stream_demux_router;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            CLK = 1'b0;
  logic            ASYNCRESET = 1'b1;
  logic [W-1:0]    I_data = '0;
  logic [SW-1:0]   I_sel = '0;
  logic            I_valid = 1'b0;
  logic            I_ready;
  logic [N*W-1:0]  O_data;
  logic [N-1:0]    O_valid;
  logic [N-1:0]    O_ready = '0;
  logic            err;
`ifdef STREAM_DEMUX_ROUTER_STATS_EN
  logic [N*16-1:0] stats;
  logic [15:0]     drops;
`endif

  stream_demux_router #(.N(N), .WIDTH(W)) dut (
    .CLK       (CLK),
    .ASYNCRESET(ASYNCRESET),
    .I_data    (I_data),
    .I_sel     (I_sel),
    .I_valid   (I_valid),
    .I_ready   (I_ready),
    .O_data    (O_data),
    .O_valid   (O_valid),
    .O_ready   (O_ready),
    .err       (err)
`ifdef STREAM_DEMUX_ROUTER_STATS_EN
    ,
    .stats     (stats),
    .drops     (drops)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } beat_t;

  beat_t       q[$];
  logic        exp_err = 1'b0;
  int          pops[N];
  int          drops_m = 0;
  logic [N-1:0] ev;
  logic        m_acc;
  logic        m_pop;

  // Sampled on the falling edge: inputs were driven 1 time unit after the rising edge.
  always @(negedge CLK) begin
    if (ASYNCRESET) begin
      q.delete();
      exp_err = 1'b0;
      for (int k = 0; k < N; k++) pops[k] = 0;
      drops_m = 0;
    end else begin
      ev = '0;
      if (q.size() > 0) ev = 3'b001 << q[0].sel;
      chk("sb_I_ready", I_ready, (q.size() < 2));
      chk("sb_O_valid", O_valid, ev);
      chk("sb_err", err, exp_err);
      if (q.size() > 0)
        for (int k = 0; k < N; k++) chk("sb_O_data", O_data[k*W +: W], q[0].data);
      m_acc = I_valid && (q.size() < 2);
      m_pop = (q.size() > 0) && O_ready[q[0].sel];
      exp_err = m_acc && (int'(I_sel) >= N);
      if (m_pop) begin
        pops[q[0].sel]++;
        void'(q.pop_front());
      end
      if (m_acc && int'(I_sel) < N) q.push_back('{sel: I_sel, data: I_data});
      if (m_acc && int'(I_sel) >= N) drops_m++;
    end
  end

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d, input logic [N-1:0] r);
    @(posedge CLK);
    #1;
    I_valid = v;
    I_sel   = s;
    I_data  = d;
    O_ready = r;
  endtask

  typedef struct {
    logic          v;
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
    logic [N-1:0]  ordy;
    logic          exp_rdy;
    logic [N-1:0]  exp_ov;
    logic [W-1:0]  exp_dat;
    logic          exp_err;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d,
                              input logic [N-1:0] r, input logic er, input logic [N-1:0] eo,
                              input logic [W-1:0] ed, input logic ee);
    vec_t t;
    t.v = v; t.sel = s; t.data = d; t.ordy = r;
    t.exp_rdy = er; t.exp_ov = eo; t.exp_dat = ed; t.exp_err = ee;
    return t;
  endfunction

  vec_t tbl[15];

  initial begin
    // Backpressure / head-of-line, then out-of-range select, then lane 2.
    tbl[0]  = mk(1, 0, 8'h11, 3'b000, 1, 3'b000, 8'h00, 0);
    tbl[1]  = mk(1, 1, 8'h22, 3'b000, 1, 3'b001, 8'h11, 0);
    tbl[2]  = mk(0, 0, 8'h00, 3'b000, 0, 3'b001, 8'h11, 0);
    tbl[3]  = mk(0, 0, 8'h00, 3'b010, 0, 3'b001, 8'h11, 0);
    tbl[4]  = mk(0, 0, 8'h00, 3'b010, 0, 3'b001, 8'h11, 0);
    tbl[5]  = mk(0, 0, 8'h00, 3'b001, 0, 3'b001, 8'h11, 0);
    tbl[6]  = mk(0, 0, 8'h00, 3'b001, 1, 3'b010, 8'h22, 0);
    tbl[7]  = mk(0, 0, 8'h00, 3'b010, 1, 3'b010, 8'h22, 0);
    tbl[8]  = mk(0, 0, 8'h00, 3'b000, 1, 3'b000, 8'h00, 0);
    tbl[9]  = mk(1, 3, 8'h5A, 3'b111, 1, 3'b000, 8'h00, 0);
    tbl[10] = mk(1, 3, 8'h5B, 3'b111, 1, 3'b000, 8'h00, 1);
    tbl[11] = mk(0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 1);
    tbl[12] = mk(1, 2, 8'h77, 3'b111, 1, 3'b000, 8'h00, 0);
    tbl[13] = mk(0, 0, 8'h00, 3'b111, 1, 3'b100, 8'h77, 0);
    tbl[14] = mk(0, 0, 8'h00, 3'b111, 1, 3'b000, 8'h00, 0);

    // ---- reset values ----
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_O_valid", O_valid, 3'b000);
    chk("rst_O_data", O_data, 24'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_I_ready", I_ready, 1'b1);
    ASYNCRESET = 1'b0;

    // ---- streaming: alternating lanes, all consumers ready ----
    for (int i = 0; i < 8; i++) begin
      step(1, SW'(i % 2), 8'hA0 + W'(i), 3'b111);
      @(negedge CLK);
      chk("stream_I_ready", I_ready, 1'b1);
      if (i > 0) begin
        chk("stream_O_valid", O_valid, 3'b001 << ((i - 1) % 2));
        chk("stream_O_data", O_data[((i - 1) % 2)*W +: W], 8'hA0 + W'(i - 1));
      end
    end
    step(0, 0, 0, 3'b111);
    @(negedge CLK);
    chk("stream_last", O_valid, 3'b010);
    chk("stream_last_dat", O_data[W +: W], 8'hA7);
    step(0, 0, 0, 3'b111);
    step(0, 0, 0, 3'b000);

    // ---- table: backpressure, HOL, bad select ----
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].ordy);
      @(negedge CLK);
      chk($sformatf("tbl%0d_I_ready", i), I_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_O_valid", i), O_valid, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      if (tbl[i].exp_ov != '0)
        for (int k = 0; k < N; k++)
          chk($sformatf("tbl%0d_O_data%0d", i, k), O_data[k*W +: W], tbl[i].exp_dat);
    end
`ifdef STREAM_DEMUX_ROUTER_STATS_EN
    for (int k = 0; k < N; k++) chk("tbl_stats", stats[k*16 +: 16], 16'(sat16(pops[k])));
    chk("tbl_drops", drops, 16'(sat16(drops_m)));
`endif

    // ---- simultaneous accept+pop in BUSY ----
    step(1, SW'($urandom_range(0, 2)), W'($urandom), 3'b111);
    for (int i = 0; i < 100; i++) begin
      step(1, SW'($urandom_range(0, 2)), W'($urandom), 3'b111);
      @(negedge CLK);
      chk("busy_I_ready", I_ready, 1'b1);
      chk("busy_occupied", (O_valid != 3'b000), 1'b1);
    end
    step(0, 0, 0, 3'b111);
    step(0, 0, 0, 3'b111);

    // ---- asynchronous reset while FULL ----
    step(1, 0, 8'h33, 3'b000);
    step(1, 2, 8'h44, 3'b000);
    step(0, 0, 0, 3'b000);
    @(negedge CLK);
    chk("pre_rst_full", I_ready, 1'b0);
    @(posedge CLK);
    #3;
    ASYNCRESET = 1'b1;
    #1;
    chk("async_O_valid", O_valid, 3'b000);
    chk("async_err", err, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
    O_ready = 3'b111;
    chk("post_rst_I_ready", I_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("no_stale", O_valid, 3'b000);
    end

`ifdef STREAM_DEMUX_ROUTER_STATS_EN
    // ---- saturating lane counter ----
    for (int i = 0; i < 70000; i++) step(1, 0, W'(i), 3'b111);
    step(0, 0, 0, 3'b111);
    step(0, 0, 0, 3'b111);
    @(negedge CLK);
    chk("stats_lane0_sat", stats[15:0], 16'hFFFF);
    chk("stats_lane0_model", stats[15:0], 16'(sat16(pops[0])));
    chk("stats_lane1_zero", stats[31:16], 16'h0);
    chk("stats_lane2_zero", stats[47:32], 16'h0);
    chk("drops_zero", drops, 16'h0);
`endif

    step(0, 0, 0, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
